// File: rtl/array_sweep_ctrl_if.sv
// ---------------------------------------------------------------------------
// array_sweep_ctrl_if
// Bundles the sweep request, the loop bounds, the status flags and the
// element write handshake of array_sweep_ctrl.
//   master : the sweep controller. It receives start, the bounds and
//            elem_ready, and drives busy, done, the elem_* bus and the
//            abort flags.
//   slave  : the requester / element sink (the opposite directions).
// Parameters: IW = index width, DW = elem_data width.
// ---------------------------------------------------------------------------
interface array_sweep_ctrl_if #(
    parameter int IW = 4,
    parameter int DW = 32
);
    logic          start;
    logic [IW-1:0] x_first;
    logic [IW-1:0] x_last;
    logic [IW-1:0] y_first;
    logic [IW-1:0] y_last;
    logic          busy;
    logic          done;
    logic          elem_valid;
    logic          elem_ready;
    logic [IW-1:0] elem_x;
    logic [IW-1:0] elem_y;
    logic [DW-1:0] elem_data;
    logic          elem_last;
    logic          bound_err;
    logic          timeout;

    modport master (
        input  start, x_first, x_last, y_first, y_last, elem_ready,
        output busy, done, elem_valid, elem_x, elem_y, elem_data,
               elem_last, bound_err, timeout
    );

    modport slave (
        output start, x_first, x_last, y_first, y_last, elem_ready,
        input  busy, done, elem_valid, elem_x, elem_y, elem_data,
               elem_last, bound_err, timeout
    );
endinterface

// File: rtl/array_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// array_sweep_ctrl
// Walks a rectangular window [x_first..x_last] x [y_first..y_last] of an
// XDIM x YDIM array in row-major order. Each element goes out on a
// valid/ready bus with data = x + y. An index outside the array aborts the
// sweep with bound_err. A watchdog aborts a sweep that runs longer than
// WDOG busy cycles, and flags it with timeout.
// Ports:
//   clk   - clock, all state changes on the rising edge
//   rst_n - synchronous active-low reset
//   sw    - master side of array_sweep_ctrl_if:
//           start + x/y bounds in, busy/done out,
//           elem_valid/elem_ready handshake, elem_x/elem_y/elem_data/elem_last,
//           bound_err/timeout sticky abort flags
// ---------------------------------------------------------------------------
module array_sweep_ctrl #(
    parameter int IW   = 4,
    parameter int DW   = 32,
    parameter int XDIM = 5,
    parameter int YDIM = 13,
    parameter int WDOG = 50000
) (
    input  logic               clk,
    input  logic               rst_n,
    array_sweep_ctrl_if.master sw
);

    // Counters carry one extra bit. A last bound of 2^IW-1 then steps to
    // 2^IW, which compares greater than the bound instead of wrapping to 0.
    localparam int CW = IW + 1;
    localparam int WW = $clog2(WDOG + 2);

    localparam logic [CW-1:0] XDIM_C = CW'(XDIM);
    localparam logic [CW-1:0] YDIM_C = CW'(YDIM);
    localparam logic [WW-1:0] WDOG_C = WW'(WDOG);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TEST_X,
        ST_TEST_Y,
        ST_ISSUE,
        ST_DONE
    } state_t;

    state_t        r_state, w_state_next;
    logic [CW-1:0] r_x, w_x_next;
    logic [CW-1:0] r_y, w_y_next;
    logic [CW-1:0] r_x_last, w_x_last_next;
    logic [CW-1:0] r_y_first, w_y_first_next;
    logic [CW-1:0] r_y_last, w_y_last_next;
    logic [WW-1:0] r_wdog, w_wdog_next;
    logic          r_bound_err, w_bound_err_next;
    logic          r_timeout, w_timeout_next;

    logic [WW-1:0] w_wdog_inc;
    logic          w_wdog_expired;
    logic [CW-1:0] w_sum;
    logic          w_valid;

    always_comb begin
        w_state_next     = r_state;
        w_x_next         = r_x;
        w_y_next         = r_y;
        w_x_last_next    = r_x_last;
        w_y_first_next   = r_y_first;
        w_y_last_next    = r_y_last;
        w_wdog_next      = r_wdog;
        w_bound_err_next = r_bound_err;
        w_timeout_next   = r_timeout;

        // The watchdog counts this busy cycle. It trips once the count
        // passes WDOG. Each working state checks it first, so an abort
        // wins over a handshake in the same cycle.
        w_wdog_inc     = r_wdog + WW'(1);
        w_wdog_expired = (w_wdog_inc > WDOG_C);

        case (r_state)
            ST_IDLE: begin
                if (sw.start) begin
                    w_x_next         = {1'b0, sw.x_first};
                    w_x_last_next    = {1'b0, sw.x_last};
                    w_y_first_next   = {1'b0, sw.y_first};
                    w_y_last_next    = {1'b0, sw.y_last};
                    w_wdog_next      = '0;
                    w_bound_err_next = 1'b0;
                    w_timeout_next   = 1'b0;
                    w_state_next     = ST_TEST_X;
                end
            end
            ST_TEST_X: begin
                w_wdog_next = w_wdog_inc;
                if (w_wdog_expired) begin
                    w_timeout_next = 1'b1;
                    w_state_next   = ST_DONE;
                end else if (r_x > r_x_last) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_y_next     = r_y_first;
                    w_state_next = ST_TEST_Y;
                end
            end
            ST_TEST_Y: begin
                w_wdog_next = w_wdog_inc;
                if (w_wdog_expired) begin
                    w_timeout_next = 1'b1;
                    w_state_next   = ST_DONE;
                end else if (r_y > r_y_last) begin
                    w_x_next     = r_x + CW'(1);
                    w_state_next = ST_TEST_X;
                end else if ((r_x >= XDIM_C) || (r_y >= YDIM_C)) begin
                    w_bound_err_next = 1'b1;
                    w_state_next     = ST_DONE;
                end else begin
                    w_state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_wdog_next = w_wdog_inc;
                if (w_wdog_expired) begin
                    w_timeout_next = 1'b1;
                    w_state_next   = ST_DONE;
                end else if (sw.elem_ready) begin
                    w_y_next     = r_y + CW'(1);
                    w_state_next = ST_TEST_Y;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_x         <= '0;
            r_y         <= '0;
            r_x_last    <= '0;
            r_y_first   <= '0;
            r_y_last    <= '0;
            r_wdog      <= '0;
            r_bound_err <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_x         <= w_x_next;
            r_y         <= w_y_next;
            r_x_last    <= w_x_last_next;
            r_y_first   <= w_y_first_next;
            r_y_last    <= w_y_last_next;
            r_wdog      <= w_wdog_next;
            r_bound_err <= w_bound_err_next;
            r_timeout   <= w_timeout_next;
        end
    end

    // Outputs decode straight from registers. The counters do not move in
    // ISSUE until the handshake, so the element bus stays stable while
    // elem_ready is low.
    assign w_valid       = (r_state == ST_ISSUE);
    assign w_sum         = {1'b0, r_x[IW-1:0]} + {1'b0, r_y[IW-1:0]};

    assign sw.busy       = (r_state != ST_IDLE);
    assign sw.done       = (r_state == ST_DONE);
    assign sw.elem_valid = w_valid;
    assign sw.elem_x     = r_x[IW-1:0];
    assign sw.elem_y     = r_y[IW-1:0];
    assign sw.elem_data  = DW'(w_sum);
    assign sw.elem_last  = w_valid && (r_x == r_x_last) && (r_y == r_y_last);
    assign sw.bound_err  = r_bound_err;
    assign sw.timeout    = r_timeout;

endmodule

// File: doc/array_sweep_ctrl.md
ARRAY_SWEEP_CTRL -- requirements
Module: array_sweep_ctrl

Interface
REQ-001 SHALL have parameter IW, 4, bit width of the X and Y index.
REQ-002 SHALL have parameter DW, 32, bit width of elem_data.
REQ-003 SHALL have parameter XDIM, 5, number of array rows; valid X indices are 0..XDIM-1.
REQ-004 SHALL have parameter YDIM, 13, number of array columns; valid Y indices are 0..YDIM-1.
REQ-005 SHALL have parameter WDOG, 50000, maximum cycles per sweep before abort.
REQ-006 SHALL have port clk, input, 1, the single clock; all state changes on rising edge.
REQ-007 SHALL have port rst_n, input, 1, reset; synchronous, active-low.
REQ-008 SHALL have port start, input, 1, sweep request, sampled in IDLE only.
REQ-009 SHALL have ports x_first and x_last, input, IW each, outer loop bounds, captured at start.
REQ-010 SHALL have ports y_first and y_last, input, IW each, inner loop bounds, captured at start.
REQ-011 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-012 SHALL have port done, output, 1, one-cycle pulse at sweep end, including aborts.
REQ-013 SHALL have ports elem_valid (output, 1) and elem_ready (input, 1), the element write handshake.
REQ-014 SHALL have ports elem_x and elem_y, output, IW each, the current element index.
REQ-015 SHALL have port elem_data, output, DW, equal to elem_x+elem_y, zero-extended.
REQ-016 SHALL have port elem_last, output, 1, high with elem_valid when x==x_last and y==y_last.
REQ-017 SHALL have ports bound_err and timeout, output, 1 each, sticky abort flags, cleared at the next accepted start.

Function
REQ-018 SHALL implement FSM states IDLE, TEST_X, TEST_Y, ISSUE and DONE.
REQ-019 SHALL, in IDLE with start=1: capture all bounds, set x=x_first, clear both flags and the watchdog, and go to TEST_X.
REQ-020 SHALL, in TEST_X: go to DONE if x>x_last; otherwise set y=y_first and go to TEST_Y.
REQ-021 SHALL, in TEST_Y: if y>y_last, set x=x+1 and go to TEST_X.
REQ-022 SHALL, in TEST_Y with y<=y_last and x>=XDIM or y>=YDIM: set bound_err and go to DONE without issuing the element.
REQ-023 SHALL, in TEST_Y otherwise, go to ISSUE.
REQ-024 SHALL, in ISSUE: drive elem_valid=1 and hold elem_x, elem_y, elem_data and elem_last stable until elem_ready=1.
REQ-025 SHALL, on an ISSUE handshake (valid and ready both high): set y=y+1 and go to TEST_Y.
REQ-026 SHALL, in DONE: pulse done for one cycle, then return to IDLE.
REQ-027 SHALL perform loop counters and comparisons in IW+1 bits, so a bound of 2^IW-1 terminates and never wraps to 0.
REQ-028 SHALL produce zero elements for an empty range (first>last on either axis) and still pulse done.
REQ-029 SHALL, from the edge sampling start (edge N), enter TEST_X at N, TEST_Y at N+1, and raise elem_valid at N+2.
REQ-030 SHALL, with elem_ready held high, issue one element every 2 cycles within a row, with 2 extra cycles per row change.
REQ-031 SHALL ignore start while busy, and SHALL NOT recapture the bounds mid-sweep.
REQ-032 SHALL increment the watchdog every busy cycle and, when it exceeds WDOG, set timeout, drop elem_valid and go to DONE; timeout has priority over a same-cycle handshake.
REQ-033 SHALL, when elem_ready rises in the same cycle a sweep starts, ignore it until ISSUE is entered.

Reset
REQ-034 SHALL, when rst_n=0 at a rising edge, set state=IDLE, busy=0, done=0, elem_valid=0, elem_last=0, bound_err=0, timeout=0, elem_x=0, elem_y=0, elem_data=0 and watchdog=0.
REQ-035 SHALL apply reset identically mid-sweep: the in-flight element is dropped, no done pulse is produced, and nothing is held over to the next start.

Verification
REQ-036 SHALL cover: x 1..4, y 1..12, ready=1 -> 48 elements row-major from (1,1,data 2) to (4,12,data 16); elem_last only on (4,12); one done pulse; no flags.
REQ-037 SHALL cover: x_first=3, x_last=2 -> no elem_valid; done 2 cycles after start, i.e. busy for 2 cycles.
REQ-038 SHALL cover: x 4..5, y 0..0 -> elements (4,0) then abort at (5,0) with bound_err=1 and done; no element with x=5 issued.
REQ-039 SHALL cover: ready toggled randomly, 0 for up to 7 cycles -> outputs stable while stalled; element sequence identical to the first scenario.
REQ-040 SHALL cover: WDOG=20, ready=0 -> timeout=1, done pulse, elem_valid low after the abort, then a new start clears timeout.
REQ-041 SHALL cover: rst_n=0 for 1 cycle in the middle of a sweep -> all outputs at reset values next cycle; a following start runs the full 48-element sweep correctly.
